// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor, DIGIT bits per clock.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, sampled only while not busy (IDLE or DONE)
//   sub               0: a+b+cin, 1: a-b-cin (cin is borrow-in)
//   a, b, cin         operands, latched on an accepted start
//   busy              operation in progress (RUN)
//   done              one-cycle pulse, result registers just updated
//   sum, cout         registered result and raw carry out of the MSB
//   ov_sgn, zero      two's-complement overflow, sum == 0
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ov_sgn,
   output logic             zero
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
   logic             sub_q, carry_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q, cout_q, ov_q, zero_q;

   logic [DIGIT-1:0] da, db;
   logic [DIGIT:0]   dsum;
   logic [WIDTH-1:0] acc_d;
   logic             carry_d, msb_cin, last;

   always_comb begin
      da      = a_q[DIGIT-1:0];
      db      = b_q[DIGIT-1:0] ^ {DIGIT{sub_q}};
      dsum    = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry_q};
      // new digit enters at the MSB end; after N digits the word is aligned
      acc_d   = WIDTH'({dsum[DIGIT-1:0], acc_q} >> DIGIT);
      carry_d = dsum[DIGIT];
      // carry into the top bit of this digit, recovered from its sum bit
      msb_cin = da[DIGIT-1] ^ db[DIGIT-1] ^ dsum[DIGIT-1];
      last    = (cnt_q == CW'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ov_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sub_q   <= sub;
                  // subtract is a + ~b + 1 - borrow_in
                  carry_q <= cin ^ sub;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               carry_q <= carry_d;
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               cnt_q   <= cnt_q + CW'(1);
               if (last) begin
                  sum_q   <= acc_d;
                  cout_q  <= carry_d;
                  ov_q    <= msb_cin ^ carry_d;
                  zero_q  <= (acc_d == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign sum    = sum_q;
   assign cout   = cout_q;
   assign ov_sgn = ov_q;
   assign zero   = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
   logic       clk, rst;
   logic       start0, sub0, cin0, start4, sub4, cin4;
   logic [7:0] a0, b0;
   logic [3:0] a4, b4;
   logic [3:0] busy_w, done_w, cout_w, ov_w, zero_w;
   logic [7:0] s0;
   logic [3:0] s1, s2, s3;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // dut 0: W8/D2, duts 1..3: W4 with D1, D2, D4 sharing one stimulus
   serial_addsub #(.WIDTH(8), .DIGIT(2)) u0 (.clk(clk), .rst(rst), .start(start0), .sub(sub0), .a(a0), .b(b0), .cin(cin0),
      .busy(busy_w[0]), .done(done_w[0]), .sum(s0), .cout(cout_w[0]), .ov_sgn(ov_w[0]), .zero(zero_w[0]));
   serial_addsub #(.WIDTH(4), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy_w[1]), .done(done_w[1]), .sum(s1), .cout(cout_w[1]), .ov_sgn(ov_w[1]), .zero(zero_w[1]));
   serial_addsub #(.WIDTH(4), .DIGIT(2)) u2 (.clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy_w[2]), .done(done_w[2]), .sum(s2), .cout(cout_w[2]), .ov_sgn(ov_w[2]), .zero(zero_w[2]));
   serial_addsub #(.WIDTH(4), .DIGIT(4)) u3 (.clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy_w[3]), .done(done_w[3]), .sum(s3), .cout(cout_w[3]), .ov_sgn(ov_w[3]), .zero(zero_w[3]));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   int WD[4] = '{8, 4, 4, 4};
   int NN[4] = '{4, 4, 2, 1};

   function automatic logic [7:0] dsum(input int k);
      case (k)
         0: return s0;
         1: return {4'b0, s1};
         2: return {4'b0, s2};
         default: return {4'b0, s3};
      endcase
   endfunction

   // Reference arithmetic from integer semantics: exact result, then wrap.
   function automatic void calc(input int w, input int av, input int bv, input int ci, input int sb,
                                output logic [7:0] s, output bit co, output bit ov, output bit z);
      int lim, r, sa, sbv, sr;
      lim = 1 << w;
      r   = sb ? av - bv - ci : av + bv + ci;
      s   = 8'(((r % lim) + lim) % lim);
      co  = sb ? (av >= bv + ci) : (r >= lim);
      sa  = (av >= lim / 2) ? av - lim : av;
      sbv = (bv >= lim / 2) ? bv - lim : bv;
      sr  = sb ? sa - sbv - ci : sa + sbv + ci;
      ov  = (sr < -(lim / 2)) || (sr >= lim / 2);
      z   = (s == 8'd0);
   endfunction

   // Cycle-level model: a request, N busy edges, a one-cycle done.
   bit         m_busy[4], m_done[4], m_cout[4], m_ov[4], m_zero[4];
   bit         p_cout[4], p_ov[4], p_zero[4];
   logic [7:0] m_sum[4], p_sum[4];
   int         m_cnt[4];
   int         dn[4];

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rst) begin
            m_busy[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
            m_sum[k] = 0; m_cout[k] = 0; m_ov[k] = 0; m_zero[k] = 0;
         end else if (m_busy[k]) begin
            if (m_cnt[k] == 1) begin
               m_busy[k] = 0; m_done[k] = 1;
               m_sum[k] = p_sum[k]; m_cout[k] = p_cout[k]; m_ov[k] = p_ov[k]; m_zero[k] = p_zero[k];
            end else m_cnt[k]--;
         end else begin
            m_done[k] = 0;
            if ((k == 0) ? start0 : start4) begin
               m_busy[k] = 1;
               m_cnt[k]  = NN[k];
               calc(WD[k], (k == 0) ? int'(a0) : int'(a4), (k == 0) ? int'(b0) : int'(b4),
                    (k == 0) ? int'(cin0) : int'(cin4), (k == 0) ? int'(sub0) : int'(sub4),
                    p_sum[k], p_cout[k], p_ov[k], p_zero[k]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            logic [12:0] got, exp;
            got = {busy_w[k], done_w[k], dsum(k), cout_w[k], ov_w[k], zero_w[k]};
            exp = {m_busy[k], m_done[k], m_sum[k], m_cout[k], m_ov[k], m_zero[k]};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL cycle dut%0d busy,done,sum,cout,ov,zero got %b %b %h %b %b %b want %b %b %h %b %b %b",
                        k, got[12], got[11], got[10:3], got[2], got[1], got[0],
                        exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
            end
            if (done_w[k] === 1'b1) dn[k]++;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic op8(input string nm, input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo, input logic ez);
      int lat;
      @(negedge clk); a0 = av; b0 = bv; cin0 = c; sub0 = s; start0 = 1;
      @(negedge clk); start0 = 0; a0 = ~av; b0 = ~bv; cin0 = ~c; sub0 = ~s;
      chk({nm, "_busy"}, 32'(busy_w[0]), 32'd1);
      lat = 0;
      while (done_w[0] !== 1'b1 && lat < 20) begin
         @(negedge clk); lat++;
      end
      chk({nm, "_lat"}, lat, 4);
      chk({nm, "_sum"}, 32'(s0), 32'(es));
      chk({nm, "_cout"}, 32'(cout_w[0]), 32'(ec));
      chk({nm, "_ov"}, 32'(ov_w[0]), 32'(eo));
      chk({nm, "_zero"}, 32'(zero_w[0]), 32'(ez));
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ps;
      bit pc, po, pz;
      int cnt, prev, idx;
      rst = 1; start0 = 0; sub0 = 0; cin0 = 0; a0 = 0; b0 = 0;
      start4 = 0; sub4 = 0; cin4 = 0; a4 = 0; b4 = 0;

      // pin the reference arithmetic against hand-computed values
      calc(8, 'h7F, 'h01, 0, 0, ps, pc, po, pz);
      chk("pin_7f_sum", 32'(ps), 32'h80); chk("pin_7f_flags", {29'd0, pc, po, pz}, 32'b010);
      calc(4, 0, 0, 1, 1, ps, pc, po, pz);
      chk("pin_4b_borrow", {20'd0, ps, 1'b0, pc, po, pz}, {20'd0, 8'h0F, 4'b0000});
      calc(4, 8, 0, 1, 1, ps, pc, po, pz);
      chk("pin_4b_ov", {20'd0, ps, 1'b0, pc, po, pz}, {20'd0, 8'h07, 4'b0110});

      @(negedge clk); @(negedge clk);
      rst = 0;
      chk_en = 1;
      chk("reset_state", {20'd0, busy_w[0], done_w[0], s0, cout_w[0], ov_w[0]}, 32'd0);

      op8("add7f", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0);
      op8("addff", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
      op8("sub00", 8'h00, 8'h01, 0, 1, 8'hFF, 0, 0, 0);
      op8("sub80", 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 0);
      op8("subcin", 8'h10, 8'h05, 1, 1, 8'h0A, 1, 0, 0);

      // back-to-back: start held high, done every N+1 cycles
      @(negedge clk); start0 = 1; a0 = 8'h11; b0 = 8'h22; cin0 = 1; sub0 = 0;
      cnt = 0; prev = -1;
      for (idx = 0; idx < 16; idx++) begin
         @(negedge clk);
         a0 = a0 + 8'h13; b0 = b0 ^ 8'h5A; sub0 = ~sub0;
         if (done_w[0] === 1'b1) begin
            if (prev >= 0) chk("b2b_spacing", idx - prev, 5);
            prev = idx; cnt++;
         end
      end
      chk("b2b_count", cnt, 3);
      start0 = 0;
      repeat (6) @(negedge clk);

      // second start pulse during RUN is ignored
      cnt = dn[0];
      @(negedge clk); start0 = 1; a0 = 8'h40; b0 = 8'h40; cin0 = 0; sub0 = 0;
      @(negedge clk); start0 = 0;
      @(negedge clk); start0 = 1; a0 = 8'h01;
      @(negedge clk); start0 = 0;
      repeat (8) @(negedge clk);
      chk("ignored_start_dones", dn[0] - cnt, 1);
      chk("ignored_start_sum", 32'(s0), 32'h80);

      // reset in the middle of an operation
      cnt = dn[0];
      @(negedge clk); start0 = 1; a0 = 8'h33; b0 = 8'h44;
      @(negedge clk); start0 = 0;
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      chk("midrst_state", {21'd0, busy_w[0], done_w[0], s0, cout_w[0], ov_w[0], zero_w[0]}, 32'd0);
      repeat (6) @(negedge clk);
      chk("midrst_no_done", dn[0] - cnt, 0);
      op8("after_rst", 8'hA5, 8'h5A, 1, 0, 8'h00, 1, 0, 1);

      // exhaustive W4 sweep on D1, D2, D4 simultaneously
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         a4 = 4'(i); b4 = 4'(i >> 4); cin4 = i[8]; sub4 = i[9]; start4 = 1;
         @(negedge clk);
         start4 = 0; a4 = ~a4; b4 = ~b4;
         repeat (5) @(negedge clk);
      end
      chk("sweep_dones_d1", dn[1], 1024);
      chk("sweep_dones_d2", dn[2], 1024);
      chk("sweep_dones_d4", dn[3], 1024);

      @(negedge clk);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle successor to the combinational n_bit_adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a start/busy/done handshake.
- Results are registered and held until the next operation completes.
- Sits in the ALU datapath wherever a wide add/sub must trade latency for area.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- DIGIT, 2, bits processed per clock. WIDTH must be an integer multiple of DIGIT. N = WIDTH/DIGIT is the number of digit cycles.

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  0: a+b+cin; 1: a-b-cin (cin acts as borrow-in)
- a  input  WIDTH  operand A, latched on an accepted start
- b  input  WIDTH  operand B, latched on an accepted start
- cin  input  1  carry/borrow in, latched on an accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result registers updated
- sum  output  WIDTH  registered result
- cout  output  1  raw carry out of the MSB (for sub: 1 = no borrow)
- ov_sgn  output  1  two's-complement overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, ov_sgn=0, zero=0.
  - Internal shift registers, carry and digit counter are cleared.
  - rst has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b and sub; set carry = cin XOR sub; counter=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - On each edge, process the low DIGIT bits of the shifted operands:
    - digit_sum = A_d + (B_d XOR {DIGIT{sub}}) + carry.
    - Shift the result digit in from the MSB end of the working sum register.
    - Update carry.
    - Increment the counter.
  - At the edge that processes digit N-1, go to DONE. In the same edge, load the outputs:
    - sum from the working register;
    - cout = final carry;
    - ov_sgn = carry into MSB XOR carry out of MSB;
    - zero = (sum == 0).
  - start is ignored in RUN.
- DONE: lasts one cycle with done=1.
  - start=1: accept a new operation exactly as in IDLE (back-to-back, no bubble); go to RUN.
  - Otherwise go to IDLE.
- Signal rules:
  - busy=1 exactly while in RUN.
  - done=1 exactly while in DONE.
  - sum, cout, ov_sgn and zero change only at the edge entering DONE, or at reset. They hold their values across IDLE and through the next RUN.
- Latency: start sampled at edge E0 gives busy=1 from E0 through E_N, and done=1 for the cycle after E_N (N+1 edges from request to result).
- Throughput: one result per N+1 cycles with back-to-back starts.
- DIGIT=WIDTH (N=1): one RUN cycle, then DONE.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - For sub=1 the result equals a - b - cin, computed as a + ~b + (1-cin).
  - cout and ov_sgn must match the combinational n_bit_adder for sub=0 on every input.
- Operand inputs may change freely after an accepted start without affecting the operation in flight.
- Reset asserted mid-RUN aborts the operation: no done pulse, and outputs clear to 0.
- Counter width is ceil(log2(N)), minimum 1 bit.

Test Plan:
- WIDTH=8, DIGIT=2, a=0x7F, b=0x01, cin=0, sub=0; start at E0 -> busy high E0..E4, done high for one cycle after E4; sum=0x80, cout=0, ov_sgn=1, zero=0.
- WIDTH=8, DIGIT=2:
  - a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ov_sgn=0, zero=1.
  - Then a=0x00, b=0x01, cin=0, sub=1 -> sum=0xFF, cout=0, ov_sgn=0.
  - Then a=0x80, b=0x01, cin=0, sub=1 -> sum=0x7F, cout=1, ov_sgn=1.
- Back-to-back: start held high continuously -> done pulses every 5 cycles. A second start pulse during RUN is ignored (no extra done). sum holds its previous value until each done.
- Reset mid-op: start at E0, rst=1 at E2 -> busy=0 and done=0 from E2 onward, sum=0, no done pulse. A fresh start at E4 completes normally.
- Exhaustive sweep for WIDTH=4 with DIGIT=1, 2 and 4: all 2^10 combinations of {sub, cin, b, a} -> sum, cout, ov_sgn and zero match the reference model. Latency is always N+1 edges.
